viterbi_output_buffer_v2: RTL and testbench

Parametrised successor to the single-width Viterbi output buffer. It accepts the decoder's serial decision bits one per cycle and packs them into DATA_WIDTH-bit words. Words are held in a FIFO_DEPTH-entry FIFO and drained over an AXI4-Stream master, with m_axis_tlast marking programmable frame boundaries. The block sits between the Viterbi traceback output and the DMA/stream interconnect, and adds explicit flush and frame-count status.

---
 rtl/viterbi_output_buffer_v2.sv | 141 ++++++++++++++
 tb/tb_viterbi_output_buffer_v2.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_output_buffer_v2.sv
// Packs serial Viterbi decision bits into DATA_WIDTH words, queues them in a FWFT FIFO
// and drains them over AXI4-Stream with framed tlast. Optional macro: VITERBI_OB_MSB_FIRST_EN.
module viterbi_output_buffer_v2 #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned FRAME_LEN_W = 16
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [FRAME_LEN_W-1:0]        frame_len,
  input  logic                          flush,
  input  logic                          s_bit_tdata,
  input  logic                          s_bit_tvalid,
  output logic                          s_bit_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [FRAME_LEN_W-1:0]        frame_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(DATA_WIDTH);
  localparam int unsigned FW = FRAME_LEN_W + 1;

  logic [DATA_WIDTH:0]    r_ram [FIFO_DEPTH];
  logic [AW:0]            r_wptr;
  logic [AW:0]            r_rptr;
  logic [DATA_WIDTH-1:0]  r_word;
  logic [CW-1:0]          r_wcnt;
  logic [FRAME_LEN_W-1:0] r_fcnt;
  logic [FRAME_LEN_W-1:0] r_flen;
  logic [FRAME_LEN_W-1:0] r_frame_count;
  logic                   r_in_frame;
  logic                   r_flush_pend;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_acc;
  logic [FRAME_LEN_W-1:0] w_flen_in;
  logic [FRAME_LEN_W-1:0] w_flen_cur;
  logic                   w_frame_done;
  logic                   w_word_full;
  logic [CW-1:0]          w_bitpos;
  logic [DATA_WIDTH-1:0]  w_word_bit;
  logic                   w_bit_close;
  logic                   w_do_flush;
  logic                   w_flush_push;
  logic                   w_push;
  logic [DATA_WIDTH:0]    w_push_data;
  logic                   w_pop;
  logic [DATA_WIDTH:0]    w_rd;

  // FIFO status from pointers; the extra MSB separates full from empty
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  assign s_bit_tready = !ARESET && !w_full && !r_flush_pend;
  assign w_acc        = s_bit_tvalid && s_bit_tready;

  // A zero frame length behaves as a one-bit frame
  assign w_flen_in    = (frame_len == '0) ? FRAME_LEN_W'(1) : frame_len;
  assign w_flen_cur   = r_in_frame ? r_flen : w_flen_in;
  assign w_frame_done = (FW'(r_fcnt) + FW'(1)) == FW'(w_flen_cur);
  assign w_word_full  = (r_wcnt == CW'(DATA_WIDTH - 1));

`ifdef VITERBI_OB_MSB_FIRST_EN
  assign w_bitpos = CW'(DATA_WIDTH - 1) - r_wcnt;
`else
  assign w_bitpos = r_wcnt;
`endif

  assign w_word_bit   = r_word | (DATA_WIDTH'(s_bit_tdata) << w_bitpos);
  assign w_bit_close  = w_acc && (w_word_full || w_frame_done);
  assign w_do_flush   = r_flush_pend && !w_full;
  assign w_flush_push = w_do_flush && ((r_wcnt != '0) || r_in_frame);
  assign w_push       = w_bit_close || w_flush_push;
  assign w_push_data  = w_flush_push ? {1'b1, r_word} : {w_frame_done, w_word_bit};
  assign w_pop        = !w_empty && m_axis_tready;

  // Storage array carries no reset; outputs are gated while empty
  always_ff @(posedge ACLK) begin
    if (w_push) r_ram[r_wptr[AW-1:0]] <= w_push_data;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_word        <= '0;
      r_wcnt        <= '0;
      r_fcnt        <= '0;
      r_flen        <= '0;
      r_frame_count <= '0;
      r_in_frame    <= 1'b0;
      r_flush_pend  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);

      if (w_acc) begin
        if (!r_in_frame) r_flen <= w_flen_in;
        if (w_frame_done) begin
          r_in_frame    <= 1'b0;
          r_fcnt        <= '0;
          r_wcnt        <= '0;
          r_word        <= '0;
          r_frame_count <= r_frame_count + FRAME_LEN_W'(1);
        end else begin
          r_in_frame <= 1'b1;
          r_fcnt     <= r_fcnt + FRAME_LEN_W'(1);
          if (w_word_full) begin
            r_wcnt <= '0;
            r_word <= '0;
          end else begin
            r_wcnt <= r_wcnt + CW'(1);
            r_word <= w_word_bit;
          end
        end
      end else if (w_flush_push) begin
        r_in_frame    <= 1'b0;
        r_fcnt        <= '0;
        r_wcnt        <= '0;
        r_word        <= '0;
        r_frame_count <= r_frame_count + FRAME_LEN_W'(1);
      end

      // Bits are blocked while a flush is pending, so flush and bit pushes never collide
      r_flush_pend <= flush || (r_flush_pend && !w_do_flush);
    end
  end

  assign w_rd          = r_ram[r_rptr[AW-1:0]];
  assign m_axis_tvalid = !w_empty;
  assign m_axis_tdata  = w_empty ? '0 : w_rd[DATA_WIDTH-1:0];
  assign m_axis_tlast  = !w_empty && w_rd[DATA_WIDTH];
  assign fifo_level    = r_wptr - r_rptr;
  assign frame_count   = r_frame_count;

endmodule

// File: tb/tb_viterbi_output_buffer_v2.sv
// Directed scoreboard bench for viterbi_output_buffer_v2 (default 32-bit, 16-deep build).
module tb_viterbi_output_buffer_v2;

  logic        ACLK;
  logic        ARESET;
  logic [15:0] frame_len;
  logic        flush;
  logic        s_bit_tdata;
  logic        s_bit_tvalid;
  logic        s_bit_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [4:0]  fifo_level;
  logic [15:0] frame_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] q[$];

  viterbi_output_buffer_v2 #(.DATA_WIDTH(32), .FIFO_DEPTH(16), .FRAME_LEN_W(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .frame_len(frame_len), .flush(flush),
    .s_bit_tdata(s_bit_tdata), .s_bit_tvalid(s_bit_tvalid), .s_bit_tready(s_bit_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .fifo_level(fifo_level), .frame_count(frame_count)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Expected word for bits sent LSB-first from v (padding falls out naturally)
  function automatic logic [31:0] place(input logic [31:0] v);
    logic [31:0] r;
`ifdef VITERBI_OB_MSB_FIRST_EN
    for (int i = 0; i < 32; i++) r[31-i] = v[i];
`else
    r = v;
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    logic acc;
    int   t;
    acc = 1'b0;
    t   = 0;
    s_bit_tdata  = b;
    s_bit_tvalid = 1'b1;
    while (!acc && t < 2000) begin
      @(negedge ACLK);
      acc = s_bit_tready;
      @(posedge ACLK);
      #1;
      t++;
    end
    s_bit_tvalid = 1'b0;
    if (!acc) begin
      n_tests++;
      n_fail++;
      $error("FAIL bit_timeout observed=0 expected=1");
    end
  endtask

  task automatic send_word(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[i]);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((q.size() != 0 || m_axis_tvalid) && t < 400) begin
      cyc(1);
      t++;
    end
    chk(tag, 64'(q.size()), 64'd0);
  endtask

  task automatic basic_frame();
    frame_len     = 16'd64;
    m_axis_tready = 1'b1;
    q.push_back({1'b0, place(32'hDEADBEEF)});
    q.push_back({1'b1, place(32'h01234567)});
    send_word(32'hDEADBEEF, 32);
    chk("latency_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("latency_tdata", 64'(m_axis_tdata), 64'(place(32'hDEADBEEF)));
    send_word(32'h01234567, 32);
    drain("t1_drain");
    chk("t1_frame_count", 64'(frame_count), 64'd1);
  endtask

  initial begin
    logic [32:0] e;
    ARESET        = 1'b1;
    frame_len     = 16'd64;
    flush         = 1'b0;
    s_bit_tdata   = 1'b0;
    s_bit_tvalid  = 1'b0;
    m_axis_tready = 1'b0;

    // Output monitor: every handshake is scored against the queue
    fork
      forever begin
        @(negedge ACLK);
        if (m_axis_tvalid && m_axis_tready) begin
          if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL unexpected_word observed=%0h expected=none", {m_axis_tlast, m_axis_tdata});
          end else begin
            e = q.pop_front();
            chk("stream_word", 64'({m_axis_tlast, m_axis_tdata}), 64'(e));
          end
        end
      end
    join_none

    cyc(3);
    chk("rst_tready", 64'(s_bit_tready), 64'd0);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_fcount", 64'(frame_count), 64'd0);
    ARESET = 1'b0;
    cyc(2);
    chk("post_rst_tready", 64'(s_bit_tready), 64'd1);

    basic_frame();

    // 40-bit frame of ones: second word is padded
    frame_len = 16'd40;
    q.push_back({1'b0, place(32'hFFFFFFFF)});
    q.push_back({1'b1, place(32'h000000FF)});
    send_word(32'hFFFFFFFF, 32);
    send_word(32'h000000FF, 8);
    drain("t2_drain");
    chk("t2_frame_count", 64'(frame_count), 64'd2);

    // frame_len of 0 is a one-bit frame
    frame_len = 16'd0;
    q.push_back({1'b1, place(32'h00000001)});
    send_bit(1'b1);
    drain("len0_drain");
    chk("len0_frame_count", 64'(frame_count), 64'd3);

    // Backpressure: fill all 16 entries, then release
    frame_len     = 16'd544;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      q.push_back({1'b0, place(32'hA5000000 ^ (32'(i) * 32'h01010101))});
      send_word(32'hA5000000 ^ (32'(i) * 32'h01010101), 32);
    end
    chk("bp_level", 64'(fifo_level), 64'd16);
    chk("bp_tready", 64'(s_bit_tready), 64'd0);
    chk("bp_head_hold", 64'(m_axis_tdata), 64'(place(32'hA5000000)));
    cyc(2);
    chk("bp_head_stable", 64'(m_axis_tdata), 64'(place(32'hA5000000)));
    m_axis_tready = 1'b1;
    q.push_back({1'b1, place(32'h5A5A1234)});
    send_word(32'h5A5A1234, 32);
    drain("bp_drain");
    chk("bp_frame_count", 64'(frame_count), 64'd4);

    // Flush closes a 5-bit partial frame
    frame_len = 16'd100;
    q.push_back({1'b1, place(32'h0000000D)});
    send_word(32'h0000000D, 5);
    pulse_flush();
    drain("flush_drain");
    chk("flush_frame_count", 64'(frame_count), 64'd5);
    frame_len = 16'd3;
    q.push_back({1'b1, place(32'h00000007)});
    send_word(32'h00000007, 3);
    drain("resample_drain");
    chk("resample_frame_count", 64'(frame_count), 64'd6);

    // Flush on the frame-completing bit yields one frame only
    frame_len = 16'd4;
    q.push_back({1'b1, place(32'h0000000F)});
    send_word(32'h00000007, 3);
    flush = 1'b1;
    send_bit(1'b1);
    flush = 1'b0;
    cyc(3);
    drain("coinc_drain");
    chk("coinc_frame_count", 64'(frame_count), 64'd7);

    // Idle flush is a no-op
    pulse_flush();
    cyc(3);
    chk("idle_flush_level", 64'(fifo_level), 64'd0);
    chk("idle_flush_fcount", 64'(frame_count), 64'd7);

    // Flush while full waits for the first pop
    frame_len     = 16'd1000;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      q.push_back({1'b0, place(32'h3C000000 + 32'(i))});
      send_word(32'h3C000000 + 32'(i), 32);
    end
    chk("ff_level", 64'(fifo_level), 64'd16);
    pulse_flush();
    cyc(4);
    chk("ff_level_held", 64'(fifo_level), 64'd16);
    chk("ff_fcount_held", 64'(frame_count), 64'd7);
    q.push_back({1'b1, 32'h00000000});
    m_axis_tready = 1'b1;
    drain("ff_drain");
    chk("ff_frame_count", 64'(frame_count), 64'd8);

    // Reset mid-frame discards everything
    frame_len     = 16'd1000;
    m_axis_tready = 1'b0;
    send_word(32'h11111111, 32);
    send_word(32'h22222222, 32);
    send_word(32'h33333333, 32);
    send_word(32'h000003FF, 10);
    chk("mid_level", 64'(fifo_level), 64'd3);
    ARESET = 1'b1;
    #1;
    q.delete();
    chk("mid_rst_tready", 64'(s_bit_tready), 64'd0);
    chk("mid_rst_level", 64'(fifo_level), 64'd0);
    chk("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("mid_rst_fcount", 64'(frame_count), 64'd0);
    cyc(2);
    ARESET = 1'b0;
    cyc(2);
    basic_frame();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
